// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes, debounces and auto-repeats active-low pushbuttons.
// Each key channel runs an independent four-state FSM clocked by a shared
// millisecond tick; every output is a registered level or single-cycle pulse.
module key_debouncer #(
   parameter int NUM_KEYS    = 3,
   parameter int TICK_COUNT  = 50000,
   parameter int DEBOUNCE_MS = 20,
   parameter int HOLD_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic                CLOCK_50,
   input  logic                KEY0,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int PW = $clog2(TICK_COUNT);
   localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
   localparam int HW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

   localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_COUNT - 1);
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MS - 1);
   // Reloading here leaves exactly REPEAT_MS ticks until hcnt hits HOLD_LAST again.
   localparam logic [HW-1:0] HOLD_RELOAD =
      (HOLD_MS >= REPEAT_MS) ? HW'(HOLD_MS - REPEAT_MS) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } state_e;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] s;
   logic [PW-1:0]       presc_q;
   logic                tick;

   state_e              state_q [NUM_KEYS];
   state_e              state_d [NUM_KEYS];
   logic [DW-1:0]       dcnt_q  [NUM_KEYS];
   logic [DW-1:0]       dcnt_d  [NUM_KEYS];
   logic [HW-1:0]       hcnt_q  [NUM_KEYS];
   logic [HW-1:0]       hcnt_d  [NUM_KEYS];
   logic [NUM_KEYS-1:0] level_q,   level_d;
   logic [NUM_KEYS-1:0] press_q,   press_d;
   logic [NUM_KEYS-1:0] release_q, release_d;
   logic [NUM_KEYS-1:0] repeat_q,  repeat_d;

   // Two-flop synchronizer per key; preset to the released level.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source, which is what makes the two stages a chain.
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   assign s    = ~sync2_q;
   assign tick = (presc_q == TICK_LAST);

   // Shared prescaler: one-cycle tick every TICK_COUNT cycles.
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) presc_q <= '0;
      else       presc_q <= tick ? '0 : presc_q + PW'(1);
   end

   // Per-key next-state logic; a change of s always takes priority over a tick.
   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      repeat_d  = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         unique case (state_q[k])
            ST_IDLE: begin
               if (s[k]) begin
                  state_d[k] = ST_PRESS_WAIT;
                  dcnt_d[k]  = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s[k]) begin
                  state_d[k] = ST_IDLE;
               end else if (tick) begin
                  if (dcnt_q[k] == DB_LAST) begin
                     state_d[k] = ST_PRESSED;
                     level_d[k] = 1'b1;
                     press_d[k] = 1'b1;
                     hcnt_d[k]  = '0;
                  end else begin
                     dcnt_d[k] = dcnt_q[k] + DW'(1);
                  end
               end
            end
            ST_PRESSED: begin
               if (!s[k]) begin
                  state_d[k] = ST_RELEASE_WAIT;
                  dcnt_d[k]  = '0;
               end else if (tick) begin
                  if (hcnt_q[k] == HOLD_LAST) begin
                     repeat_d[k] = 1'b1;
                     hcnt_d[k]   = HOLD_RELOAD;
                  end else begin
                     hcnt_d[k] = hcnt_q[k] + HW'(1);
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (s[k]) begin
                  state_d[k] = ST_PRESSED;
               end else if (tick) begin
                  if (dcnt_q[k] == DB_LAST) begin
                     state_d[k]   = ST_IDLE;
                     level_d[k]   = 1'b0;
                     release_d[k] = 1'b1;
                  end else begin
                     dcnt_d[k] = dcnt_q[k] + DW'(1);
                  end
               end
            end
            default: state_d[k] = ST_IDLE;
         endcase
      end
   end

   // FSM state, counters and registered outputs.
   // NOTE: the per-key arrays are a handful of control flops, not a RAM, so they
   // are reset with everything else to drop any half-finished debounce or hold.
   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            state_q[k] <= ST_IDLE;
            dcnt_q[k]  <= '0;
            hcnt_q[k]  <= '0;
         end
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         repeat_q  <= '0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         hcnt_q    <= hcnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed stimulus with a cycle-level reference model that
// pushes expected pulses into a scoreboard queue; a negedge monitor pops them.
module tb_key_debouncer;

   localparam int NK = 3;
   localparam int TC = 4;
   localparam int DB = 3;
   localparam int HM = 5;
   localparam int RM = 2;

   typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT} ev_kind_e;
   typedef struct {
      int       cyc;
      int       key;
      ev_kind_e kind;
   } ev_t;

   logic          CLOCK_50 = 1'b0;
   logic          KEY0;
   logic [NK-1:0] key_in;
   logic [NK-1:0] key_level, key_press, key_release, key_repeat;

   int n_checks = 0;
   int n_fail   = 0;

   ev_t exp_q[$];

   // Reference model state
   int            m_cyc;
   int            m_ph;
   logic [NK-1:0] m_sync1, m_sync2, m_sprev, m_lvl;
   int            m_run  [NK];
   int            m_hold [NK];

   // Monitor statistics
   int press_cnt [NK];
   int rel_cnt   [NK];
   int rep_cnt   [NK];
   int press_cyc [NK];
   int rel_cyc   [NK];
   int rep2_q[$];

   key_debouncer #(
      .NUM_KEYS   (NK),
      .TICK_COUNT (TC),
      .DEBOUNCE_MS(DB),
      .HOLD_MS    (HM),
      .REPEAT_MS  (RM)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .KEY0       (KEY0),
      .key_in     (key_in),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_repeat (key_repeat)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic ev_t mk_ev(input int c, input int k, input ev_kind_e kd);
      ev_t e;
      e.cyc  = c;
      e.key  = k;
      e.kind = kd;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int v, input int lo, input int hi);
      n_checks++;
      assert (v >= lo && v <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #2;
   endtask

   // Reference model: a change is accepted after DB ticks with the sample held
   // away from the accepted level; repeats fall on held-tick counts HM, HM+RM, ...
   always @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         m_cyc   <= 0;
         m_ph    <= 0;
         m_sync1 <= '1;
         m_sync2 <= '1;
         m_sprev <= '0;
         m_lvl   <= '0;
         for (int k = 0; k < NK; k++) begin
            m_run[k]  <= 0;
            m_hold[k] <= 0;
         end
         exp_q.delete();
      end else begin
         m_cyc   <= m_cyc + 1;
         m_ph    <= (m_ph == TC - 1) ? 0 : m_ph + 1;
         m_sync1 <= key_in;
         m_sync2 <= m_sync1;
         m_sprev <= ~m_sync2;
         for (int k = 0; k < NK; k++) begin
            if ((~m_sync2[k]) == m_lvl[k]) begin
               m_run[k] <= 0;
               if (m_lvl[k] && m_sprev[k] && (m_ph == TC - 1)) begin
                  m_hold[k] <= m_hold[k] + 1;
                  if ((m_hold[k] + 1 >= HM) && (((m_hold[k] + 1 - HM) % RM) == 0))
                     exp_q.push_back(mk_ev(m_cyc + 1, k, EV_REPEAT));
               end
            end else if ((~m_sync2[k]) == m_sprev[k]) begin
               if (m_ph == TC - 1) begin
                  if (m_run[k] + 1 == DB) begin
                     m_lvl[k] <= ~m_sync2[k];
                     m_run[k] <= 0;
                     if (!m_sync2[k]) begin
                        m_hold[k] <= 0;
                        exp_q.push_back(mk_ev(m_cyc + 1, k, EV_PRESS));
                     end else begin
                        exp_q.push_back(mk_ev(m_cyc + 1, k, EV_RELEASE));
                     end
                  end else begin
                     m_run[k] <= m_run[k] + 1;
                  end
               end
            end else begin
               m_run[k] <= 0;
            end
         end
      end
   end

   // Monitor: pop this cycle's expected pulses and compare every output.
   initial begin
      ev_t           e;
      logic [NK-1:0] exp_p, exp_r, exp_t;
      for (int k = 0; k < NK; k++) begin
         press_cnt[k] = 0; rel_cnt[k] = 0; rep_cnt[k] = 0;
         press_cyc[k] = 0; rel_cyc[k] = 0;
      end
      forever begin
         @(negedge CLOCK_50);
         if (KEY0 === 1'b1) begin
            exp_p = '0;
            exp_r = '0;
            exp_t = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc <= m_cyc) begin
               e = exp_q.pop_front();
               if (e.cyc < m_cyc) check("stale expectation", e.cyc, m_cyc);
               case (e.kind)
                  EV_PRESS:   exp_p[e.key] = 1'b1;
                  EV_RELEASE: exp_r[e.key] = 1'b1;
                  default:    exp_t[e.key] = 1'b1;
               endcase
            end
            check("key_press", key_press, exp_p);
            check("key_release", key_release, exp_r);
            check("key_repeat", key_repeat, exp_t);
            check("key_level", key_level, m_lvl);
            for (int k = 0; k < NK; k++) begin
               if (key_press[k])   begin press_cnt[k]++; press_cyc[k] = m_cyc; end
               if (key_release[k]) begin rel_cnt[k]++;   rel_cyc[k]   = m_cyc; end
               if (key_repeat[k])  rep_cnt[k]++;
            end
            if (key_repeat[2]) rep2_q.push_back(m_cyc);
         end
      end
   end

   // Directed sequence
   initial begin
      int t0, t1, p0, p1, r0, r1, nrep;
      KEY0   = 1'b0;
      key_in = '1;
      wait_cyc(3);
      check("reset level", key_level, 0);
      check("reset press", key_press, 0);
      check("reset release", key_release, 0);
      check("reset repeat", key_repeat, 0);
      KEY0 = 1'b1;
      wait_cyc(5);

      // 1: clean press on key 0
      t0 = m_cyc; p0 = press_cnt[0];
      key_in[0] = 1'b0;
      wait_cyc(40);
      check("t1 press count", press_cnt[0] - p0, 1);
      check_range("t1 press latency", press_cyc[0] - t0, 12, 15);
      check("t1 level held", key_level[0], 1);
      key_in[0] = 1'b1;
      wait_cyc(20);
      check("t1 level released", key_level[0], 0);

      // 2: key 1 bouncing every 5 cycles is rejected
      p1 = press_cnt[1]; r1 = rel_cnt[1];
      for (int i = 0; i < 12; i++) begin
         key_in[1] = ~key_in[1];
         wait_cyc(5);
      end
      wait_cyc(10);
      check("t2 no press", press_cnt[1] - p1, 0);
      check("t2 no release", rel_cnt[1] - r1, 0);
      check("t2 level low", key_level[1], 0);

      // 3: long hold on key 2 with auto-repeat
      t0 = m_cyc;
      key_in[2] = 1'b0;
      wait_cyc(100);
      check("t3 press count", press_cnt[2], 1);
      check_range("t3 press latency", press_cyc[2] - t0, 12, 15);
      check_range("t3 repeats seen", rep2_q.size(), 2, 20);
      if (rep2_q.size() > 0) check("t3 first repeat offset", rep2_q[0] - press_cyc[2], 20);
      for (int i = 1; i < rep2_q.size(); i++)
         check("t3 repeat interval", rep2_q[i] - rep2_q[i-1], 8);
      t1 = m_cyc; r0 = rel_cnt[2];
      key_in[2] = 1'b1;
      wait_cyc(3);
      nrep = rep2_q.size();
      wait_cyc(22);
      check("t3 release count", rel_cnt[2] - r0, 1);
      check_range("t3 release latency", rel_cyc[2] - t1, 12, 15);
      check("t3 no repeat after release", rep2_q.size(), nrep);
      check("t3 level low", key_level[2], 0);

      // 4: reset mid-hold, key still held afterwards
      p0 = press_cnt[0]; r0 = rel_cnt[0];
      key_in[0] = 1'b0;
      wait_cyc(20);
      check("t4 level before reset", key_level[0], 1);
      KEY0 = 1'b0;
      #1;
      check("t4 reset level", key_level, 0);
      check("t4 reset press", key_press, 0);
      check("t4 reset release", key_release, 0);
      check("t4 reset repeat", key_repeat, 0);
      wait_cyc(3);
      KEY0 = 1'b1;
      t1 = m_cyc;
      wait_cyc(20);
      check("t4 press count", press_cnt[0] - p0, 2);
      check_range("t4 fresh press latency", press_cyc[0] - t1, 12, 15);
      check("t4 no release", rel_cnt[0] - r0, 0);
      check("t4 level held", key_level[0], 1);
      key_in[0] = 1'b1;
      wait_cyc(25);
      check("t4 level released", key_level[0], 0);

      // 5: simultaneous press on keys 0 and 1
      p0 = press_cnt[0]; p1 = press_cnt[1];
      key_in[1:0] = 2'b00;
      wait_cyc(20);
      check("t5 press count k0", press_cnt[0] - p0, 1);
      check("t5 press count k1", press_cnt[1] - p1, 1);
      check("t5 press coincide", press_cyc[0], press_cyc[1]);
      key_in[0] = 1'b1;
      wait_cyc(25);

      // 6: short release glitch on held key 1
      r1 = rel_cnt[1]; nrep = rep_cnt[1];
      key_in[1] = 1'b1;
      wait_cyc(6);
      key_in[1] = 1'b0;
      wait_cyc(40);
      check("t6 no release", rel_cnt[1] - r1, 0);
      check("t6 level held", key_level[1], 1);
      check_range("t6 repeats continue", rep_cnt[1] - nrep, 1, 20);
      key_in[1] = 1'b1;
      wait_cyc(25);
      check("t6 final release", rel_cnt[1] - r1, 1);
      check("t6 level released", key_level[1], 0);

      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
